data_memory_ctrl: RTL

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_if.sv | 24 ++
 rtl/data_memory_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load/store requester and data_memory_ctrl.
// master = requester side, slave = memory controller side.
interface data_memory_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-outstanding RISC-V style load/store controller over a DEPTH x 32 word array.
// Optional macro DATA_MEMORY_CTRL_MISALIGN_TRAP_EN: misaligned half/word accesses error out instead of being aligned down.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | req_ready=1, waiting for a request
// S_WAIT | request latched, counting WAIT_CYCLES wait states
// S_RESP | resp_valid=1, holding the response until resp_ready
module data_memory_ctrl #(
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   data_memory_ctrl_if.slave      bus,
   input  logic [DEPTH-1:0][31:0] initial_values,
   output logic [DEPTH-1:0][31:0] memory_check
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic [DEPTH-1:0][31:0]  mem;

   logic                    lat_write;
   logic [2:0]              lat_funct3;
   logic [AW+1:0]           lat_addr;
   logic [31:0]             lat_wdata;

   logic                    req_ready_q;
   logic                    resp_valid_q;
   logic                    resp_err_q;
   logic [31:0]             resp_rdata_q;

   logic                    sel_write;
   logic [2:0]              sel_funct3;
   logic [AW+1:0]           sel_addr;
   logic [31:0]             sel_wdata;

   logic                    accept;
   logic                    enter_resp;
   logic [1:0]              size;
   logic                    funct_ok;
   logic                    misaligned;
   logic                    acc_err;
   logic [1:0]              lane;
   logic [AW-1:0]           idx;
   logic [31:0]             rd_word;
   logic [31:0]             shifted;
   logic [31:0]             load_data;
   logic [31:0]             wr_word;

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign memory_check   = mem;

   assign accept     = bus.req_valid && req_ready_q;
   assign enter_resp = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state == S_WAIT) && (cnt == 4'd0));

   // With zero wait states the access happens on the acceptance edge itself,
   // so the live bus fields stand in for the not-yet-latched ones.
   always_comb begin
      sel_write  = lat_write;
      sel_funct3 = lat_funct3;
      sel_addr   = lat_addr;
      sel_wdata  = lat_wdata;
      if (state == S_IDLE) begin
         sel_write  = bus.req_write;
         sel_funct3 = bus.req_funct3;
         sel_addr   = bus.req_addr[AW+1:0];
         sel_wdata  = bus.req_wdata;
      end
   end

   always_comb begin
      size       = sel_funct3[1:0];
      funct_ok   = sel_write ? (!sel_funct3[2] && (size != 2'b11))
                             : ((size != 2'b11) && !(sel_funct3[2] && (size == 2'b10)));
      misaligned = ((size == 2'b01) && sel_addr[0]) ||
                   ((size == 2'b10) && (sel_addr[1:0] != 2'b00));
`ifdef DATA_MEMORY_CTRL_MISALIGN_TRAP_EN
      acc_err    = !funct_ok || misaligned;
      lane       = sel_addr[1:0];
`else
      acc_err    = !funct_ok;
      lane       = (size == 2'b10) ? 2'b00 :
                   (size == 2'b01) ? {sel_addr[1], 1'b0} : sel_addr[1:0];
`endif
      idx        = sel_addr[AW+1:2];
      rd_word    = mem[idx];
      shifted    = rd_word >> {lane, 3'b000};

      case (sel_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = 32'd0;
      endcase

      wr_word = rd_word;
      case (size)
         2'b00:   wr_word[{lane, 3'b000} +: 8]        = sel_wdata[7:0];
         2'b01:   wr_word[{lane[1], 4'b0000} +: 16]   = sel_wdata[15:0];
         default: wr_word                             = sel_wdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         lat_write    <= 1'b0;
         lat_funct3   <= 3'd0;
         lat_addr     <= '0;
         lat_wdata    <= 32'd0;
         mem          <= initial_values;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_write   <= bus.req_write;
                  lat_funct3  <= bus.req_funct3;
                  lat_addr    <= bus.req_addr[AW+1:0];
                  lat_wdata   <= bus.req_wdata;
                  req_ready_q <= 1'b0;
                  cnt         <= CNT_LOAD;
                  state       <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               // req_ready only rises after this edge, so no same-edge accept
               if (bus.resp_ready) begin
                  state        <= S_IDLE;
                  req_ready_q  <= 1'b1;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= 32'd0;
                  resp_err_q   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (enter_resp) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (acc_err || sel_write) ? 32'd0 : load_data;
            if (!acc_err && sel_write) begin
               mem[idx] <= wr_word;
            end
         end
      end
   end

endmodule
